fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction-fetch sequencer that owns the program counter and drives the address of the asynchronous-read instruction ROM.
- Captures each fetched word into a small prefetch queue and presents it to decode over a valid/ready handshake.
- Handles branch/jump redirects by flushing the queue, and stops fetching at an ebreak.
- Sits between the instruction ROM and the decode stage.

Parameters:
- ADDRESS_WIDTH, 5, ROM word-address width; ROM holds 2^ADDRESS_WIDTH words.
- DATA_WIDTH, 32, instruction width.
- PC_WIDTH, 32, byte-address program counter width.
- QUEUE_DEPTH, 2, prefetch queue entries; power of two, minimum 2.
- RESET_PC, 32'h0, PC value loaded on reset.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; asynchronous, active-high.
- fetch_en  in  1  permits fetching when high.
- rom_addr  out  ADDRESS_WIDTH  word address to the ROM, equal to fpc[ADDRESS_WIDTH+1:2].
- rom_instr  in  DATA_WIDTH  ROM data, combinational from rom_addr.
- redirect_valid  in  1  branch/jump taken this cycle.
- redirect_pc  in  PC_WIDTH  redirect target as a byte address.
- instr_valid  out  1  queue head is valid.
- instr  out  DATA_WIDTH  queue-head instruction; NOP (32'h00000013) when empty.
- instr_pc  out  PC_WIDTH  PC of the queue head; 0 when empty.
- instr_ready  in  1  decode accepts the head this cycle.
- halted  out  1  FSM is in S_HALT.

Behaviour:
- Reset (async, while rst is high):
  - fpc = RESET_PC, queue empty, FSM = S_BOOT.
  - instr_valid = 0, instr = NOP, instr_pc = 0, halted = 0.
- FSM:
  - S_BOOT -> S_RUN on the first clock edge after rst deasserts. No fetch occurs in S_BOOT.
  - S_RUN -> S_HALT when a pushed word equals EBREAK (32'h00100073). The ebreak itself is enqueued; fpc stops at ebreak PC + 4.
  - S_HALT -> S_RUN on redirect_valid.
  - Any state -> S_BOOT on rst.
- Pop: pop = instr_valid && instr_ready.
- Push:
  - push = (state == S_RUN) && fetch_en && !redirect_valid && (!full || pop).
  - Entry stored is {fpc, rom_instr}, then fpc <= fpc + 4.
  - A push and a pop in the same cycle while full is legal; occupancy is unchanged.
- Latency:
  - A word pushed at edge N is visible on instr/instr_valid after edge N, i.e. one cycle fetch-to-valid.
  - Steady-state throughput is one instruction per cycle while instr_ready stays high.
- Redirect (redirect_valid = 1):
  - Same edge: queue flushed (including any pop attempt), fpc <= {redirect_pc[PC_WIDTH-1:2], 2'b00}, no push.
  - instr_valid is 0 the following cycle; the first target instruction is valid one cycle after that.
  - A redirect in S_BOOT is ignored.
- Arithmetic and addressing:
  - fpc increments modulo 2^PC_WIDTH.
  - rom_addr truncates, so fetch wraps modulo ROM size: the PC after word 2^ADDRESS_WIDTH-1 addresses word 0, while instr_pc keeps the full untruncated value.
- fetch_en low: no push and fpc holds; pops continue.
- Empty queue: instr and instr_pc hold their constant empty values; decode sees instr_valid = 0.
- rst mid-operation: all state clears immediately (asynchronously) and the queue contents are lost.

Decomposition:
- Package fetch_pkg:
  - Constants NOP_INSTR = 32'h00000013 and EBREAK_INSTR = 32'h00100073.
  - Enum fetch_state_t {S_BOOT, S_RUN, S_HALT}.
  - Struct fetch_entry_t {pc, instr}.
- Sub-module fetch_queue:
  - Synchronous FIFO of fetch_entry_t with push, pop, flush, full and empty.
  - Flush has priority over push and pop.
  - Uses the same clk/rst convention.

Test Plan:
- Reset then free run, ROM words 0..4 distinct, instr_ready = 1 -> instr_valid first high 2 cycles after rst falls; instr_pc sequence 0, 4, 8, 12, 16 on consecutive cycles.
- instr_ready = 0 for 5 cycles from reset -> queue fills to 2 entries holding PC 0 and PC 4; fpc holds at 8, rom_addr = 2; releasing instr_ready delivers 0, 4, 8 back-to-back with no gap.
- Redirect to 32'h0000000E while the queue holds 2 entries -> instr_valid = 0 next cycle, rom_addr = 3, next valid instr_pc = 32'hC; the flushed entries are never presented.
- ROM word 3 = EBREAK -> entries for PC 0..12 delivered, halted = 1, rom_addr frozen at 4, instr_valid = 0 once drained; redirect to 0 -> halted = 0 and fetch restarts at PC 0.
- Free run past PC 124 with ADDRESS_WIDTH = 5 -> rom_addr wraps 31 -> 0 while instr_pc = 128 carries ROM word 0.
- Assert rst asynchronously mid-stream with the queue full -> instr_valid = 0 and instr = NOP before the next edge; after release, the first instr_pc = RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch slice.
// Provides the NOP/EBREAK encodings, the fetch FSM state type and the
// prefetch queue entry layout ({pc, instr}).
package fetch_pkg;

  localparam int FETCH_PC_W   = 32;
  localparam int FETCH_DATA_W = 32;

  localparam logic [FETCH_DATA_W-1:0] NOP_INSTR    = 32'h00000013;
  localparam logic [FETCH_DATA_W-1:0] EBREAK_INSTR = 32'h00100073;

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [FETCH_PC_W-1:0]   pc;
    logic [FETCH_DATA_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Prefetch queue: synchronous FIFO of fetch_entry_t.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset (empties the queue)
//   push_i     : write entry_i (ignored when full unless popping same cycle)
//   entry_i    : entry to store
//   pop_i      : drop the head entry (ignored when empty)
//   flush_i    : discard all entries; wins over push_i and pop_i
//   head_o     : current head entry (undefined content when empty)
//   full_o     : all DEPTH entries occupied
//   empty_o    : no entries held
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  fetch_entry_t entry_i,
  input  logic         pop_i,
  input  logic         flush_i,
  output fetch_entry_t head_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int PTR_W = $clog2(DEPTH);

  fetch_entry_t     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q,  count_d;
  logic             wr_en, rd_en;

  assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rd_ptr_q];

  // A write into a full queue is allowed only when the head leaves the
  // same cycle, so occupancy stays at DEPTH.
  assign wr_en = push_i && !flush_i && (!full_o || pop_i);
  assign rd_en = pop_i && !flush_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
      if (rd_en) rd_ptr_d = rd_ptr_q + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: empty_o masks stale content.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= entry_i;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch sequencer. Owns the byte-address fetch PC, addresses an
// asynchronous-read ROM, buffers fetched words in a prefetch queue and
// presents the head to decode.
// Handshake: the head is transferred on a rising edge where instr_valid and
// instr_ready are both high; instr/instr_pc are stable while instr_valid is
// high and not yet accepted, and hold NOP/0 while the queue is empty.
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   fetch_en        : permit fetching
//   rom_addr        : ROM word address (fpc[ADDRESS_WIDTH+1:2])
//   rom_instr       : ROM data, combinational from rom_addr
//   redirect_valid  : branch/jump taken; flushes the queue
//   redirect_pc     : redirect target byte address (low 2 bits dropped)
//   instr_valid     : queue head valid
//   instr, instr_pc : queue head instruction and its PC
//   instr_ready     : decode accepts the head
//   halted          : fetch stopped after an ebreak
//   state_dbg       : current FSM state (fetch_state_t encoding)
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int                   ADDRESS_WIDTH = 5,
  parameter int                   DATA_WIDTH    = FETCH_DATA_W,
  parameter int                   PC_WIDTH      = FETCH_PC_W,
  parameter int                   QUEUE_DEPTH   = 2,
  parameter logic [PC_WIDTH-1:0]  RESET_PC      = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     fetch_en,
  output logic [ADDRESS_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0]    rom_instr,
  input  logic                     redirect_valid,
  input  logic [PC_WIDTH-1:0]      redirect_pc,
  output logic                     instr_valid,
  output logic [DATA_WIDTH-1:0]    instr,
  output logic [PC_WIDTH-1:0]      instr_pc,
  input  logic                     instr_ready,
  output logic                     halted,
  output logic [1:0]               state_dbg
);

  fetch_state_t          state_q, state_d;
  logic [PC_WIDTH-1:0]   fpc_q, fpc_d;
  fetch_entry_t          push_entry, head;
  logic                  q_full, q_empty;
  logic                  pop, push, flush;

  assign rom_addr    = fpc_q[ADDRESS_WIDTH+1:2];
  assign instr_valid = !q_empty;
  assign instr       = q_empty ? NOP_INSTR : head.instr;
  assign instr_pc    = q_empty ? '0 : head.pc;
  assign halted      = (state_q == S_HALT);
  assign state_dbg   = state_q;

  assign pop   = instr_valid && instr_ready;
  assign push  = (state_q == S_RUN) && fetch_en && !redirect_valid && (!q_full || pop);
  // Redirects during boot are ignored entirely.
  assign flush = redirect_valid && (state_q != S_BOOT);

  assign push_entry.pc    = fpc_q;
  assign push_entry.instr = rom_instr;

  always_comb begin
    state_d = state_q;
    fpc_d   = fpc_q;
    case (state_q)
      S_BOOT: state_d = S_RUN;
      S_RUN:  if (push && (rom_instr == EBREAK_INSTR)) state_d = S_HALT;
      S_HALT: if (redirect_valid) state_d = S_RUN;
      default: state_d = S_BOOT;
    endcase
    if (flush) begin
      fpc_d = redirect_pc & ~PC_WIDTH'(3);
    end else if (push) begin
      fpc_d = fpc_q + PC_WIDTH'(4);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_BOOT;
      fpc_q   <= RESET_PC;
    end else begin
      state_q <= state_d;
      fpc_q   <= fpc_d;
    end
  end

  fetch_queue #(.DEPTH(QUEUE_DEPTH)) u_queue (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .entry_i (push_entry),
    .pop_i   (pop),
    .flush_i (flush),
    .head_o  (head),
    .full_o  (q_full),
    .empty_o (q_empty)
  );

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  localparam logic [31:0] NOP    = 32'h00000013;
  localparam logic [31:0] EBREAK = 32'h00100073;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        fetch_en;
  logic [4:0]  rom_addr;
  logic [31:0] rom_instr;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;
  logic        halted;
  logic [1:0]  state_dbg;

  logic [31:0] rom [32];
  assign rom_instr = rom[rom_addr];

  int checks   = 0;
  int failures = 0;

  fetch_unit dut (
    .clk            (clk),
    .rst            (rst),
    .fetch_en       (fetch_en),
    .rom_addr       (rom_addr),
    .rom_instr      (rom_instr),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .instr_ready    (instr_ready),
    .halted         (halted),
    .state_dbg      (state_dbg)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // advance one edge and settle
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic ready);
    rst            = 1'b1;
    fetch_en       = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    instr_ready    = ready;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rom[i] = 32'h1000_0000 + 32'(i * 16'h0101);

    // T1: reset values and free run
    do_reset(1'b1);
    #1;
    check("rst_valid",  {31'b0, instr_valid}, 32'd0);
    check("rst_instr",  instr, NOP);
    check("rst_pc",     instr_pc, 32'd0);
    check("rst_halted", {31'b0, halted}, 32'd0);
    check("rst_addr",   {27'b0, rom_addr}, 32'd0);
    tick();
    check("boot_valid", {31'b0, instr_valid}, 32'd0);
    tick();
    check("run_valid", {31'b0, instr_valid}, 32'd1);
    check("run_pc0",   instr_pc, 32'd0);
    check("run_in0",   instr, rom[0]);
    for (int k = 1; k <= 4; k++) begin
      tick();
      check("run_pc",  instr_pc, 32'(4 * k));
      check("run_in",  instr, rom[k]);
    end

    // T2: backpressure fills the queue, then back-to-back delivery
    do_reset(1'b0);
    for (int k = 0; k < 5; k++) tick();
    check("bp_valid", {31'b0, instr_valid}, 32'd1);
    check("bp_pc0",   instr_pc, 32'd0);
    check("bp_addr",  {27'b0, rom_addr}, 32'd2);
    instr_ready = 1'b1;
    tick();
    check("bp_pc4", instr_pc, 32'd4);
    tick();
    check("bp_pc8", instr_pc, 32'd8);
    check("bp_in8", instr, rom[2]);

    // T3: redirect flushes a full queue (pop attempt included)
    do_reset(1'b0);
    for (int k = 0; k < 3; k++) tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000000E;
    instr_ready    = 1'b1;
    tick();
    redirect_valid = 1'b0;
    check("rd_valid", {31'b0, instr_valid}, 32'd0);
    check("rd_addr",  {27'b0, rom_addr}, 32'd3);
    tick();
    check("rd_valid2", {31'b0, instr_valid}, 32'd1);
    check("rd_pc",     instr_pc, 32'hC);
    check("rd_in",     instr, rom[3]);
    tick();
    check("rd_pc_nxt", instr_pc, 32'h10);

    // T4: ebreak halts fetch, redirect restarts
    rom[3] = EBREAK;
    do_reset(1'b1);
    tick();
    for (int k = 0; k < 4; k++) begin
      tick();
      check("eb_pc", instr_pc, 32'(4 * k));
    end
    check("eb_in",     instr, EBREAK);
    check("eb_halted", {31'b0, halted}, 32'd1);
    check("eb_addr",   {27'b0, rom_addr}, 32'd4);
    tick();
    check("eb_drain",  {31'b0, instr_valid}, 32'd0);
    check("eb_addr2",  {27'b0, rom_addr}, 32'd4);
    check("eb_halt2",  {31'b0, halted}, 32'd1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0;
    tick();
    redirect_valid = 1'b0;
    check("eb_unhalt", {31'b0, halted}, 32'd0);
    check("eb_rvalid", {31'b0, instr_valid}, 32'd0);
    tick();
    check("eb_restart_v",  {31'b0, instr_valid}, 32'd1);
    check("eb_restart_pc", instr_pc, 32'd0);
    rom[3] = 32'h1000_0000 + 32'(3 * 16'h0101);

    // T5: ROM address wrap past PC 124
    do_reset(1'b1);
    tick();
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'd124;
    tick();
    redirect_valid = 1'b0;
    check("wr_addr31", {27'b0, rom_addr}, 32'd31);
    tick();
    check("wr_pc124", instr_pc, 32'd124);
    check("wr_in31",  instr, rom[31]);
    check("wr_addr0", {27'b0, rom_addr}, 32'd0);
    tick();
    check("wr_pc128", instr_pc, 32'd128);
    check("wr_in0",   instr, rom[0]);

    // T6: asynchronous reset mid-stream with a full queue
    do_reset(1'b0);
    for (int k = 0; k < 3; k++) tick();
    check("ar_full_v", {31'b0, instr_valid}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("ar_valid", {31'b0, instr_valid}, 32'd0);
    check("ar_instr", instr, NOP);
    check("ar_pc",    instr_pc, 32'd0);
    check("ar_addr",  {27'b0, rom_addr}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    instr_ready = 1'b1;
    tick();
    tick();
    check("ar_first_v",  {31'b0, instr_valid}, 32'd1);
    check("ar_first_pc", instr_pc, 32'd0);

    // T7: redirect during boot is ignored
    do_reset(1'b1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h40;
    tick();
    redirect_valid = 1'b0;
    check("bt_addr", {27'b0, rom_addr}, 32'd0);
    tick();
    check("bt_pc", instr_pc, 32'd0);
    check("bt_v",  {31'b0, instr_valid}, 32'd1);

    // T8: fetch_en low holds fpc, pops continue
    fetch_en = 1'b0;
    tick();
    check("fe_valid", {31'b0, instr_valid}, 32'd0);
    check("fe_addr",  {27'b0, rom_addr}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
